// File: rtl/o_delay_ctrl_pkg.sv
// Shared types for the O_DELAY tap controller: tap width, command opcodes, FSM states.
package o_delay_ctrl_pkg;

  localparam int TAP_W = 6;
  localparam logic [TAP_W-1:0] TAP_MAX = 6'd63;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_SET  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_PULSE  = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

endpackage

// File: rtl/o_delay_tap_ctrl.sv
// Turns load/inc/dec/set tap commands into spaced DLY_LOAD/DLY_ADJ pulses for one O_DELAY.
// Optional O_DELAY_TAP_CHECK_EN: compare tap feedback after settling, flag ERR and resync.
//
// state  | meaning
// IDLE   | ready for a command
// LOAD   | DLY_LOAD high for one cycle
// CHECK  | compare tracked tap with target, pick direction
// PULSE  | DLY_ADJ high for one cycle
// SETTLE | SETTLE_CYCLES quiet cycles while O_DELAY catches up
module o_delay_tap_ctrl
  import o_delay_ctrl_pkg::*;
#(
  parameter int DELAY         = 0,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [TAP_W-1:0] CMD_TAP,
  input  logic [TAP_W-1:0] DLY_TAP_VALUE,
  output logic             DLY_LOAD,
  output logic             DLY_ADJ,
  output logic             DLY_INCDEC,
  output logic [TAP_W-1:0] TAP_OUT,
  output logic             BUSY,
`ifdef O_DELAY_TAP_CHECK_EN
  output logic             ERR,
`endif
  output logic             DONE
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] target_q, target_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             adj_q, adj_d;
  logic             incdec_q, incdec_d;
  logic             done_q, done_d;
  logic             is_load_q, is_load_d;
`ifdef O_DELAY_TAP_CHECK_EN
  logic             err_q, err_d;
`else
  logic             unused_fb;
  assign unused_fb = ^DLY_TAP_VALUE;
`endif

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    incdec_d  = incdec_q;
    is_load_d = is_load_q;
    load_d    = 1'b0;
    adj_d     = 1'b0;
    done_d    = 1'b0;
`ifdef O_DELAY_TAP_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          is_load_d = 1'b0;
          state_d   = ST_CHECK;
          case (cmd_op_e'(CMD_OP))
            OP_LOAD: begin
              is_load_d = 1'b1;
              load_d    = 1'b1;
              state_d   = ST_LOAD;
            end
            OP_INC:  target_d = (tap_q == TAP_MAX) ? tap_q : tap_q + 6'd1;
            OP_DEC:  target_d = (tap_q == '0) ? tap_q : tap_q - 6'd1;
            OP_SET:  target_d = CMD_TAP;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        tap_d   = TAP_W'(DELAY);
        cnt_d   = SETTLE_LAST;
        state_d = ST_SETTLE;
      end
      ST_CHECK: begin
        if (tap_q == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          incdec_d = (target_q > tap_q);
          adj_d    = 1'b1;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        tap_d   = incdec_q ? tap_q + 6'd1 : tap_q - 6'd1;
        cnt_d   = SETTLE_LAST;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
`ifdef O_DELAY_TAP_CHECK_EN
          // Trust the hardware over the mirror so the next CHECK steers from reality.
          if (DLY_TAP_VALUE != tap_q) begin
            err_d = 1'b1;
            tap_d = DLY_TAP_VALUE;
          end
`endif
          if (is_load_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tap_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      adj_q     <= 1'b0;
      incdec_q  <= 1'b0;
      done_q    <= 1'b0;
      is_load_q <= 1'b0;
`ifdef O_DELAY_TAP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      adj_q     <= adj_d;
      incdec_q  <= incdec_d;
      done_q    <= done_d;
      is_load_q <= is_load_d;
`ifdef O_DELAY_TAP_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign CMD_READY  = (state_q == ST_IDLE);
  assign BUSY       = (state_q != ST_IDLE);
  assign DLY_LOAD   = load_q;
  assign DLY_ADJ    = adj_q;
  assign DLY_INCDEC = incdec_q;
  assign TAP_OUT    = tap_q;
  assign DONE       = done_q;
`ifdef O_DELAY_TAP_CHECK_EN
  assign ERR        = err_q;
`endif

endmodule

// File: doc/o_delay_tap_ctrl.md
# o_delay_tap_ctrl

Sequencing controller for one O_DELAY output delay line. It accepts tap commands (load, increment, decrement, set-to-target) over a valid/ready interface. Each command becomes a correctly spaced sequence of DLY_LOAD / DLY_ADJ / DLY_INCDEC pulses. The controller tracks the current tap and reports completion. It sits between the calibration or host register logic and the O_DELAY instance, in the same clock domain as that instance.

## Interface
- DELAY, 0: must equal the DELAY parameter of the driven O_DELAY (0-63); expected tap after a load.
- SETTLE_CYCLES, 3: idle cycles after each pulse before the tap is re-evaluated; legal range 2-15.

- CLK_IN  in  1  clock; shared with the O_DELAY CLK_IN.
- RST  in  1  reset, synchronous and active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  controller can accept a command.
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 SET.
- CMD_TAP  in  6  target tap for SET; ignored for other ops.
- DLY_TAP_VALUE  in  6  tap feedback from O_DELAY.
- DLY_LOAD  out  1  to O_DELAY.
- DLY_ADJ  out  1  to O_DELAY.
- DLY_INCDEC  out  1  to O_DELAY; 1 = increment.
- TAP_OUT  out  6  tracked tap value.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky feedback-mismatch flag; present only with O_DELAY_TAP_CHECK_EN.

## Operation
- FSM states: IDLE, LOAD, CHECK, PULSE, SETTLE.
- All outputs are registered.
- A command is accepted on an edge where CMD_VALID && CMD_READY. CMD_READY = (state == IDLE).
- On accept, the controller latches op and target:
  - INC: target = min(tap_q+1, 63).
  - DEC: target = max(tap_q-1, 0).
  - SET: target = CMD_TAP.
- LOAD sequence: DLY_LOAD=1 for exactly 1 cycle, then SETTLE, then IDLE with DONE=1. tap_q <= DELAY.
- INC/DEC/SET go to CHECK:
  - tap_q == target: IDLE with DONE=1. No pulse is issued, so saturation at 0/63 is silent.
  - Otherwise: DLY_INCDEC <= (target > tap_q), then PULSE.
- PULSE: DLY_ADJ=1 for exactly 1 cycle. In the following edge, tap_q moves ±1.
- SETTLE: DLY_ADJ=0 and DLY_LOAD=0 for SETTLE_CYCLES cycles. The state then returns to CHECK (step commands) or IDLE (load).
- DLY_INCDEC is held constant from CHECK through the end of SETTLE, because O_DELAY samples it unsynchronised two edges after ADJ rises.
- DLY_ADJ always has at least SETTLE_CYCLES low cycles between pulses, so every pulse produces a fresh rising edge.
- BUSY = (state != IDLE).
- TAP_OUT = tap_q.
- Commands presented while BUSY stall; they are never dropped or queued.

## Timing
- Cycle n is the cycle after accept edge n=0.
- LOAD: DLY_LOAD high in cycle 1; SETTLE in cycles 2..1+S; DONE in cycle 2+S (cycle 5 at S=3).
- Step commands: CHECK in cycle 1. Each step costs S+2 cycles (CHECK, PULSE, S×SETTLE). DONE arrives at cycle (S+2)·n + 2 for n steps (17 for 3 steps at S=3). A no-op finishes with DONE in cycle 2.
- CMD_READY is high in the DONE cycle, so back-to-back commands are allowed.
- O_DELAY updates its tap 2 edges after DLY_ADJ/DLY_LOAD rises. S≥2 guarantees the feedback is valid when SETTLE ends.
- Reset values:
  - state IDLE.
  - tap_q = 0, matching O_DELAY power-up.
  - DLY_LOAD=0, DLY_ADJ=0, DLY_INCDEC=0, BUSY=0, DONE=0, ERR=0.
  - CMD_READY=1 from the first cycle after reset.
- Reset mid-command aborts immediately; any pulse already registered by O_DELAY may still take effect. Software must issue LOAD after a reset.

## Configuration
- O_DELAY_TAP_CHECK_EN defined:
  - In the last SETTLE cycle, DLY_TAP_VALUE is compared with tap_q.
  - On mismatch: ERR is set (cleared only by RST) and tap_q <= DLY_TAP_VALUE, so the next CHECK works from actual hardware state.
- Not defined:
  - DLY_TAP_VALUE is unused.
  - ERR is absent.
  - tap_q is purely open-loop.

## Structure
- Package o_delay_ctrl_pkg holds:
  - TAP_W=6, TAP_MAX=63.
  - The CMD_OP enum (OP_LOAD, OP_INC, OP_DEC, OP_SET).
  - The FSM state enum.
- Single module, no sub-module; the 4-bit settle counter and the tap mirror are inline.

## Test plan
- Reset, then LOAD with DELAY=20, S=3 -> DLY_LOAD pulse in cycle 1, DONE in cycle 5, TAP_OUT=20, DLY_TAP_VALUE=20.
- SET 13 from tap 10 -> exactly 3 DLY_ADJ pulses with DLY_INCDEC=1, spaced 5 cycles apart; DONE at cycle 17; TAP_OUT=13.
- SET 0 from 2, then DEC at tap 0 -> 2 decrement pulses; the DEC produces no pulse and DONE in cycle 2.
- INC at tap 63 and SET equal to current tap -> no DLY_ADJ pulse, DONE in cycle 2, TAP_OUT unchanged.
- CMD_VALID held during a SET in progress -> CMD_READY low, command accepted in the DONE cycle and executed next. RST asserted mid-SET -> all outputs at reset values next cycle.
- With O_DELAY_TAP_CHECK_EN: force DLY_TAP_VALUE off by one -> ERR=1 (sticky), TAP_OUT resyncs, and a subsequent SET still reaches the target.
